// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - two-road traffic light controller with pedestrian walk phase
// Timing counts ticks from the upstream divider; lamps are a Moore decode of the state register.
module traffic_light_ctrl #(
   parameter int GREEN_MIN_TICKS = 4,
   parameter int YELLOW_TICKS    = 3,
   parameter int ALLRED_TICKS    = 1,
   parameter int WALK_TICKS      = 5,
   parameter int CW              = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       ta,
   input  logic       tb,
   input  logic       ped_req,
   output logic [1:0] la,
   output logic [1:0] lb,
   output logic       walk,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      AG  = 3'd0,
      AY  = 3'd1,
      AR1 = 3'd2,
      BG  = 3'd3,
      BY  = 3'd4,
      AR2 = 3'd5,
      PW  = 3'd6
   } state_t;

   localparam logic [1:0] LAMP_G = 2'b00;
   localparam logic [1:0] LAMP_Y = 2'b01;
   localparam logic [1:0] LAMP_R = 2'b10;

   localparam logic [CW-1:0] GREEN_LAST  = CW'(GREEN_MIN_TICKS - 1);
   localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_TICKS - 1);
   localparam logic [CW-1:0] ALLRED_LAST = CW'(ALLRED_TICKS - 1);
   localparam logic [CW-1:0] WALK_LAST   = CW'(WALK_TICKS - 1);

   // Plain vector register so an undefined code (7) can exist and be recovered from.
   logic [2:0]    state_q;
   state_t        state_d;
   logic [CW-1:0] timer_q;
   logic [CW-1:0] timer_d;
   logic [CW-1:0] limit_last;
   logic          ped_pend_q;
   logic          ped_pend_d;
   logic          dir_b_q;
   logic          dir_b_d;
   logic          phase_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= AG;
         timer_q    <= '0;
         ped_pend_q <= 1'b0;
         dir_b_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         ped_pend_q <= ped_pend_d;
         dir_b_q    <= dir_b_d;
      end
   end

   always_comb begin
      limit_last = '0;
      case (state_q)
         AG, BG:   limit_last = GREEN_LAST;
         AY, BY:   limit_last = YELLOW_LAST;
         AR1, AR2: limit_last = ALLRED_LAST;
         PW:       limit_last = WALK_LAST;
         default:  limit_last = '0;
      endcase
   end

   // Timer never passes limit_last, so equality doubles as "minimum reached" in greens.
   assign phase_done = (timer_q == limit_last);

   always_comb begin
      state_d = AG;
      dir_b_d = dir_b_q;
      case (state_q)
         AG: begin
            state_d = AG;
            if (tick && phase_done && (!ta || ped_pend_q)) state_d = AY;
         end
         AY: begin
            state_d = AY;
            if (tick && phase_done) state_d = AR1;
         end
         AR1: begin
            state_d = AR1;
            if (tick && phase_done) begin
               state_d = ped_pend_q ? PW : BG;
               dir_b_d = 1'b1;
            end
         end
         BG: begin
            state_d = BG;
            if (tick && phase_done && (!tb || ped_pend_q)) state_d = BY;
         end
         BY: begin
            state_d = BY;
            if (tick && phase_done) state_d = AR2;
         end
         AR2: begin
            state_d = AR2;
            if (tick && phase_done) begin
               state_d = ped_pend_q ? PW : AG;
               dir_b_d = 1'b0;
            end
         end
         PW: begin
            state_d = PW;
            if (tick && phase_done) state_d = dir_b_q ? BG : AG;
         end
         default: state_d = AG;
      endcase
   end

   // State only moves on ticks, except the illegal-code escape which also clears the timer.
   always_comb begin
      timer_d = timer_q;
      if (state_d != state_q) begin
         timer_d = '0;
      end else if (tick && !phase_done) begin
         timer_d = timer_q + 1'b1;
      end
   end

   // Requests are dropped while walk is showing or about to show; otherwise they stick.
   always_comb begin
      ped_pend_d = ped_pend_q | ped_req;
      if (state_q == PW || state_d == PW) ped_pend_d = 1'b0;
   end

   always_comb begin
      la   = LAMP_R;
      lb   = LAMP_R;
      walk = 1'b0;
      case (state_q)
         AG:      la = LAMP_G;
         AY:      la = LAMP_Y;
         BG:      lb = LAMP_G;
         BY:      lb = LAMP_Y;
         PW:      walk = 1'b1;
         default: ;
      endcase
   end

   assign state_o = state_q;

endmodule
